cpu_top: RTL and testbench
==========================

# cpu_top

Top-level wrapper for a toy 5-stage pipelined MIPS32 subset processor. It instantiates the core and an instruction ROM. It is the unit exercised by program-level benches that preload ROM contents and check architectural register values cycle by cycle. The core is scoped to ORI execution with full EX/MEM result forwarding; every other encoding retires as a no-op.

## Interface
- ROM_DEPTH, 64: instruction ROM depth in 32-bit words.
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- No other ports. Benches observe state hierarchically.

## Operation
- Hierarchy paths are fixed: ROM array `rom.memory[0:ROM_DEPTH-1]`, 32-bit words, loadable by `$readmemh`. Register file array `openmips.regfile.regs[0:31]`, 32-bit.
- PC is a byte address. ROM read is combinational: `instr = memory[pc[31:2]]`. Addresses at or beyond ROM_DEPTH read 0, which is a no-op.
- Pipeline stages: IF, ID, EX, MEM, WB. Registers IF/ID, ID/EX, EX/MEM and MEM/WB sit between them. No stalls and no branches; PC advances by 4 every cycle.
- ORI: opcode [31:26]=6'b001101, rs=[25:21], rt=[20:16], imm=[15:0]. Result is `rt = rs | {16'h0, imm}`.
- Any other opcode is a no-op: write enable 0, no register change.
- Writes to $0 are discarded. $0 always reads 0.
- ID operand selection, in priority order:
  - EX-stage result if EX writes the same nonzero register.
  - Otherwise MEM-stage result if MEM writes it.
  - Otherwise the register-file read.
- The register file is write-through: a same-cycle read of the register being written in WB returns the new value.

## Timing
- While rst=0: PC=0, all pipeline registers hold a no-op (write enable 0, data 0), all regs[*]=0.
- Edge numbering: edge 1 is the first rising clk edge with rst=1.
- Instruction at word k is latched into IF/ID at edge k+1.
- Its result is written to the register file at edge k+5, giving a latency of 5 edges.
- Throughput is 1 instruction per cycle.
- Back-to-back dependent ORIs run without bubbles; each dependent result lands exactly one edge after its producer's.
- Reset asserted mid-program clears all state asynchronously. After release, fetch restarts from word 0.

## Configuration
- FORWARDING_EN defined: EX and MEM forwarding paths active, as described above.
- FORWARDING_EN undefined: ID reads only the write-through register file.
  - A consumer sees a producer's result only when it sits 3 or more instructions later.
  - Closer dependents read the stale value; no interlock is provided.

## Structure
- Shared package holds:
  - opcode constants (ORI=6'b001101);
  - register-index width (5) and data width (32);
  - the no-op pipeline-register reset value.
- One natural sub-module: `regfile`. It has 2 combinational read ports, 1 write port with write-through, and $0 hardwired to zero.
- Core, named `openmips`, contains the stage logic and forwarding mux. Instance `rom` holds `memory`.

## Test plan
- Reset: hold rst=0 for 10 cycles, then release. Before edge 5, all regs are 0 and PC is 0, 4, 8 on successive edges.
- Forwarding chain:
  - Program: words 0-2 = 0 (no-op); word 3 ori $5,$0,0x1100; word 4 ori $5,$5,0x0020; word 5 ori $5,$5,0x4400; word 6 ori $5,$5,0x0044.
  - Required $5 after edges 8, 9, 10, 11: 0x00001100, 0x00001120, 0x00005520, 0x00005564.
- MEM-distance forward: ori $2,$0,0x00F0; nop; ori $3,$2,0x000F. Required: $3=0x000000FF at edge 8.
- WB write-through: ori $2,$0,0x8000; nop; nop; ori $4,$2,0x0001. Required: $4=0x00008001.
- $0 protection: ori $0,$0,0xFFFF; ori $6,$0,0x0001. Required: $0=0 and $6=0x00000001; no forwarding from $0.
- Reset mid-run: assert rst=0 during the chain. Required: all regs 0 immediately. After release, the same $5 sequence repeats at edges 8-11.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the toy MIPS32 ORI pipeline: opcodes, widths and
// the no-op values loaded into pipeline registers on reset.
package cpu_pkg;

    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    localparam logic [5:0] OP_ORI = 6'b001101;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] opa;
        logic [15:0]       imm;
    } idex_t;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] waddr;
        logic [DATA_W-1:0] data;
    } wb_t;

    localparam idex_t IDEX_NOP = '{we: 1'b0, waddr: '0, opa: '0, imm: '0};
    localparam wb_t   WB_NOP   = '{we: 1'b0, waddr: '0, data: '0};

    function automatic logic [DATA_W-1:0] ori_result(input logic [DATA_W-1:0] a,
                                                    input logic [15:0] imm);
        return a | {16'h0000, imm};
    endfunction

endpackage

// File: rtl/cpu_core.sv
// 5-stage ORI-only pipeline core. Define FORWARDING_EN to enable EX/MEM
// result forwarding into ID; otherwise ID relies on register-file write-through.
module cpu_core
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [31:0] pc_o,
    input  logic [31:0] instr_i
);

    logic [31:0]       pc_q;
    logic [31:0]       ifid_q;
    idex_t             idex_q, idex_d;
    wb_t               exmem_q, exmem_d;
    wb_t               memwb_q;

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs, rt;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rf_rdata1, rdata2_unused;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] ex_result;

    assign pc_o = pc_q;

    assign opcode = ifid_q[31:26];
    assign rs     = ifid_q[25:21];
    assign rt     = ifid_q[20:16];
    assign imm    = ifid_q[15:0];

    cpu_regfile regfile (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .raddr1_i (rs),
        .rdata1_o (rf_rdata1),
        .raddr2_i (rt),
        .rdata2_o (rdata2_unused),
        .we_i     (memwb_q.we),
        .waddr_i  (memwb_q.waddr),
        .wdata_i  (memwb_q.data)
    );

    assign ex_result = ori_result(idex_q.opa, idex_q.imm);

    // ID operand: youngest in-flight producer wins over older ones
    always_comb begin
        opa = rf_rdata1;
`ifdef FORWARDING_EN
        if (idex_q.we && (idex_q.waddr != '0) && (idex_q.waddr == rs))
            opa = ex_result;
        else if (exmem_q.we && (exmem_q.waddr != '0) && (exmem_q.waddr == rs))
            opa = exmem_q.data;
`endif
    end

    always_comb begin
        idex_d = IDEX_NOP;
        if (opcode == OP_ORI)
            idex_d = '{we: 1'b1, waddr: rt, opa: opa, imm: imm};
    end

    always_comb begin
        exmem_d = WB_NOP;
        if (idex_q.we)
            exmem_d = '{we: 1'b1, waddr: idex_q.waddr, data: ex_result};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= '0;
            ifid_q  <= '0;
            idex_q  <= IDEX_NOP;
            exmem_q <= WB_NOP;
            memwb_q <= WB_NOP;
        end else begin
            pc_q    <= pc_q + 32'd4;
            ifid_q  <= instr_i;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= exmem_q;
        end
    end

endmodule

// File: rtl/cpu_regfile.sv
// 32 x 32-bit register file: two combinational read ports, one write port,
// write-through on same-cycle read, $0 hardwired to zero.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs [0:31];

    function automatic logic [DATA_W-1:0] rd(input logic [REG_AW-1:0] a,
                                            input logic [DATA_W-1:0] stored);
        if (a == '0)
            return '0;
        else if (we_i && (waddr_i == a))
            return wdata_i;
        else
            return stored;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (we_i && (waddr_i != '0)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = rd(raddr1_i, regs[raddr1_i]);
    assign rdata2_o = rd(raddr2_i, regs[raddr2_i]);

endmodule

// File: rtl/cpu_rom.sv
// Combinational instruction ROM; out-of-range byte addresses read 0 (no-op).
module cpu_rom #(
    parameter int ROM_DEPTH = 64
) (
    input  logic [31:0] addr_i,
    output logic [31:0] data_o
);

    localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

    logic [31:0] memory [0:ROM_DEPTH-1];
    logic        unused_lsb;

    assign unused_lsb = ^addr_i[1:0];

    always_comb begin
        data_o = '0;
        if (addr_i[31:2] < 30'(ROM_DEPTH))
            data_o = memory[addr_i[AW+1:2]];
    end

endmodule

// File: rtl/cpu_top.sv
// Top-level wrapper: pipeline core (instance openmips) fetching from an
// instruction ROM (instance rom). Forwarding is selected by FORWARDING_EN.
module cpu_top #(
    parameter int ROM_DEPTH = 64
) (
    input  logic clk,
    input  logic rst
);

    logic [31:0] pc;
    logic [31:0] instr;

    cpu_rom #(.ROM_DEPTH(ROM_DEPTH)) rom (
        .addr_i (pc),
        .data_o (instr)
    );

    cpu_core openmips (
        .clk_i   (clk),
        .rst_ni  (rst),
        .pc_o    (pc),
        .instr_i (instr)
    );

endmodule

// File: tb/tb_cpu_top.sv
// Directed program-level bench for cpu_top; expectations follow FORWARDING_EN.
module tb_cpu_top;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] chain_exp [0:3];
    logic [31:0] mem_fwd_exp;
    logic [31:0] acc;

    cpu_top #(.ROM_DEPTH(64)) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ori(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
        return {6'b001101, rs, rt, imm};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 64; i++)
            dut.rom.memory[i] = 32'h0;
    endtask

    task automatic load_chain;
        clear_rom();
        dut.rom.memory[3] = ori(5'd0, 5'd5, 16'h1100);
        dut.rom.memory[4] = ori(5'd5, 5'd5, 16'h0020);
        dut.rom.memory[5] = ori(5'd5, 5'd5, 16'h4400);
        dut.rom.memory[6] = ori(5'd5, 5'd5, 16'h0044);
    endtask

    // Leaves rst released on a falling edge, so the next rising edge is edge 1.
    task automatic release_reset;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
`ifdef FORWARDING_EN
        chain_exp[0] = 32'h0000_1100;
        chain_exp[1] = 32'h0000_1120;
        chain_exp[2] = 32'h0000_5520;
        chain_exp[3] = 32'h0000_5564;
        mem_fwd_exp  = 32'h0000_00FF;
`else
        chain_exp[0] = 32'h0000_1100;
        chain_exp[1] = 32'h0000_0020;
        chain_exp[2] = 32'h0000_4400;
        chain_exp[3] = 32'h0000_1144;
        mem_fwd_exp  = 32'h0000_000F;
`endif

        // Reset and forwarding chain
        rst = 1'b0;
        load_chain();
        @(negedge clk);
        check_eq("rst_pc", dut.openmips.pc_q, 32'h0);
        check_eq("rst_r5", dut.openmips.regfile.regs[5], 32'h0);
        release_reset();
        tick(1); check_eq("pc_e1", dut.openmips.pc_q, 32'd4);
        tick(1); check_eq("pc_e2", dut.openmips.pc_q, 32'd8);
        tick(1); check_eq("pc_e3", dut.openmips.pc_q, 32'd12);
        tick(1);
        acc = 32'h0;
        for (int i = 0; i < 32; i++)
            acc = acc | dut.openmips.regfile.regs[i];
        check_eq("regs_e4_zero", acc, 32'h0);
        tick(3); check_eq("chain_r5_e7", dut.openmips.regfile.regs[5], 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check_eq($sformatf("chain_r5_e%0d", 8 + i), dut.openmips.regfile.regs[5], chain_exp[i]);
        end

        // Reset mid-run
        rst = 1'b0;
        load_chain();
        release_reset();
        tick(9);
        check_eq("mid_r5_e9", dut.openmips.regfile.regs[5], chain_exp[1]);
        rst = 1'b0;
        #1;
        acc = 32'h0;
        for (int i = 0; i < 32; i++)
            acc = acc | dut.openmips.regfile.regs[i];
        check_eq("mid_regs_zero", acc, 32'h0);
        check_eq("mid_pc_zero", dut.openmips.pc_q, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        tick(7); check_eq("rerun_r5_e7", dut.openmips.regfile.regs[5], 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check_eq($sformatf("rerun_r5_e%0d", 8 + i), dut.openmips.regfile.regs[5], chain_exp[i]);
        end

        // MEM-distance dependency
        rst = 1'b0;
        clear_rom();
        dut.rom.memory[1] = ori(5'd0, 5'd2, 16'h00F0);
        dut.rom.memory[3] = ori(5'd2, 5'd3, 16'h000F);
        release_reset();
        tick(7); check_eq("memfwd_r3_e7", dut.openmips.regfile.regs[3], 32'h0);
        tick(1); check_eq("memfwd_r3_e8", dut.openmips.regfile.regs[3], mem_fwd_exp);
        check_eq("memfwd_r2", dut.openmips.regfile.regs[2], 32'h0000_00F0);

        // WB write-through at distance 3
        rst = 1'b0;
        clear_rom();
        dut.rom.memory[0] = ori(5'd0, 5'd2, 16'h8000);
        dut.rom.memory[3] = ori(5'd2, 5'd4, 16'h0001);
        release_reset();
        tick(8);
        check_eq("wt_r4_e8", dut.openmips.regfile.regs[4], 32'h0000_8001);
        check_eq("wt_r2", dut.openmips.regfile.regs[2], 32'h0000_8000);

        // $0 protection, then run past the end of the ROM
        rst = 1'b0;
        clear_rom();
        dut.rom.memory[0] = ori(5'd0, 5'd0, 16'hFFFF);
        dut.rom.memory[1] = ori(5'd0, 5'd6, 16'h0001);
        release_reset();
        tick(6);
        check_eq("zero_r6_e6", dut.openmips.regfile.regs[6], 32'h0000_0001);
        check_eq("zero_r0_e6", dut.openmips.regfile.regs[0], 32'h0);
        tick(71);
        check_eq("oob_pc_e77", dut.openmips.pc_q, 32'd308);
        check_eq("oob_r6", dut.openmips.regfile.regs[6], 32'h0000_0001);
        check_eq("oob_r0", dut.openmips.regfile.regs[0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
